// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - unified word RAM, memory-mapped output register and byte-stream boot loader
module mem_responder #(
    parameter int          DEPTH_LOG2 = 8,
    parameter logic [15:0] IO_ADDR    = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           addr,
    input  logic [15:0]           writedata,
    input  logic                  memwrite,
    output logic [15:0]           readdata,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  cpu_hold,
    output logic [15:0]           io_out,
    output logic [DEPTH_LOG2:0]   loaded_words
);

    localparam int                    DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_MAX    = {DEPTH_LOG2{1'b1}};
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        LOAD_LO = 2'd0,
        LOAD_HI = 2'd1,
        RUN     = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [15:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_ptr;
    logic [7:0]            r_latch;
    logic [DEPTH_LOG2:0]   r_loaded;
    logic                  r_cpu_hold;
    logic [15:0]           r_io_out;

    logic                  w_xfer;
    logic                  w_ld_we;
    logic [15:0]           w_ld_wdata;
    logic                  w_is_io;
    logic                  w_cpu_we;
    logic                  w_io_we;
    logic [DEPTH_LOG2-1:0] w_cpu_idx;

    assign ld_ready     = (r_state != RUN);
    assign w_xfer       = ld_valid && ld_ready;
    assign w_is_io      = (addr == IO_ADDR);
    assign w_cpu_idx    = addr[DEPTH_LOG2-1:0];
    // The CPU only gets the write port once the loader has finished.
    assign w_cpu_we     = (r_state == RUN) && memwrite && !w_is_io;
    assign w_io_we      = (r_state == RUN) && memwrite && w_is_io;

    assign readdata     = w_is_io ? r_io_out : r_mem[w_cpu_idx];
    assign cpu_hold     = r_cpu_hold;
    assign io_out       = r_io_out;
    assign loaded_words = r_loaded;

    always_comb begin
        w_state_next = r_state;
        w_ld_we      = 1'b0;
        w_ld_wdata   = 16'h0000;
        case (r_state)
            LOAD_LO: begin
                if (w_xfer) begin
                    if (ld_last) begin
                        w_ld_we      = 1'b1;
                        w_ld_wdata   = {8'h00, ld_data};
                        w_state_next = RUN;
                    end else begin
                        w_state_next = LOAD_HI;
                    end
                end
            end
            LOAD_HI: begin
                if (w_xfer) begin
                    w_ld_we    = 1'b1;
                    w_ld_wdata = {ld_data, r_latch};
                    // A full RAM terminates the image even without ld_last.
                    if (ld_last || (r_ptr == PTR_MAX)) begin
                        w_state_next = RUN;
                    end else begin
                        w_state_next = LOAD_LO;
                    end
                end
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= LOAD_LO;
            r_cpu_hold <= 1'b1;
            r_io_out   <= 16'h0000;
            r_loaded   <= '0;
            r_ptr      <= '0;
            r_latch    <= 8'h00;
        end else begin
            r_state    <= w_state_next;
            r_cpu_hold <= (w_state_next != RUN);
            if (w_xfer && (r_state == LOAD_LO)) begin
                r_latch <= ld_data;
            end
            if (w_ld_we) begin
                if (r_loaded != FULL_COUNT) begin
                    r_loaded <= r_loaded + 1'b1;
                end
                if ((r_state == LOAD_HI) && (r_ptr != PTR_MAX)) begin
                    r_ptr <= r_ptr + 1'b1;
                end
            end
            if (w_io_we) begin
                r_io_out <= writedata;
            end
        end
    end

    // RAM has no reset so a partial image survives a mid-load reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (w_ld_we) begin
                r_mem[r_ptr] <= w_ld_wdata;
            end else if (w_cpu_we) begin
                r_mem[w_cpu_idx] <= writedata;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr, writedata, readdata;
    logic        memwrite;
    logic        ld_valid, ld_last, ld_ready, cpu_hold;
    logic [7:0]  ld_data;
    logic [15:0] io_out;
    logic [8:0]  loaded_words;

    logic [15:0] s_addr, s_writedata, s_readdata, s_io_out;
    logic        s_memwrite, s_ld_valid, s_ld_last, s_ld_ready, s_cpu_hold;
    logic [7:0]  s_ld_data;
    logic [2:0]  s_loaded_words;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_responder u_dut (
        .clk(clk), .reset(reset), .addr(addr), .writedata(writedata),
        .memwrite(memwrite), .readdata(readdata), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .cpu_hold(cpu_hold), .io_out(io_out), .loaded_words(loaded_words)
    );

    mem_responder #(.DEPTH_LOG2(2)) u_small (
        .clk(clk), .reset(reset), .addr(s_addr), .writedata(s_writedata),
        .memwrite(s_memwrite), .readdata(s_readdata), .ld_valid(s_ld_valid),
        .ld_data(s_ld_data), .ld_last(s_ld_last), .ld_ready(s_ld_ready),
        .cpu_hold(s_cpu_hold), .io_out(s_io_out), .loaded_words(s_loaded_words)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic read_word(input string tag, input logic [15:0] a, input logic [15:0] exp);
        @(negedge clk);
        addr = a;
        #1;
        check(tag, readdata, exp);
    endtask

    task automatic write_word(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        addr      = a;
        writedata = d;
        memwrite  = 1'b1;
        @(posedge clk);
        #1;
        memwrite  = 1'b0;
    endtask

    initial begin
        reset = 1'b0; addr = '0; writedata = '0; memwrite = 1'b0;
        ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        s_addr = '0; s_writedata = '0; s_memwrite = 1'b0;
        s_ld_valid = 1'b0; s_ld_data = '0; s_ld_last = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_ld_ready", ld_ready, 1);
        check("rst_io_out", io_out, 16'h0000);
        check("rst_loaded", loaded_words, 0);
        reset = 1'b1;

        // Overflow on the 4-word instance: ten bytes, no ld_last.
        for (int i = 1; i <= 10; i++) begin
            check($sformatf("ovf_ready_%0d", i), s_ld_ready, (i <= 8) ? 1 : 0);
            s_ld_valid = 1'b1;
            s_ld_data  = 8'h10 + 8'(i);
            @(posedge clk);
            #1;
        end
        s_ld_valid = 1'b0;
        check("ovf_loaded", s_loaded_words, 4);
        check("ovf_hold", s_cpu_hold, 0);
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            s_addr = 16'(w);
            #1;
            check($sformatf("ovf_ram%0d", w), s_readdata,
                  {8'h12 + 8'(2 * w), 8'h11 + 8'(2 * w)});
        end

        // Even image with hold/ready timing.
        send_byte(8'h34, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h78, 1'b0);
        check("t1_hold_before_last", cpu_hold, 1);
        send_byte(8'h56, 1'b1);
        check("t1_hold_after_last", cpu_hold, 0);
        check("t1_ready_run", ld_ready, 0);
        check("t1_loaded", loaded_words, 2);
        read_word("t1_ram0", 16'h0000, 16'h1234);
        read_word("t1_ram1", 16'h0001, 16'h5678);

        // Loader is ignored in RUN.
        send_byte(8'h99, 1'b1);
        check("run_ld_ignored", loaded_words, 2);
        read_word("run_ram0_kept", 16'h0000, 16'h1234);

        // RUN-phase CPU access and aliasing.
        write_word(16'h0005, 16'hBEEF);
        read_word("run_rd5", 16'h0005, 16'hBEEF);
        read_word("run_alias105", 16'h0105, 16'hBEEF);
        write_word(16'h00FF, 16'h7777);
        write_word(16'hFFFF, 16'h00A5);
        check("run_io_out", io_out, 16'h00A5);
        read_word("run_rd_io", 16'hFFFF, 16'h00A5);
        read_word("run_ram255", 16'h00FF, 16'h7777);

        // Odd image: final byte lands as a zero-extended low byte.
        do_reset();
        check("t2_io_reset", io_out, 16'h0000);
        check("t2_hold_reset", cpu_hold, 1);
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        send_byte(8'hEF, 1'b1);
        check("t2_loaded", loaded_words, 2);
        check("t2_ready", ld_ready, 0);
        check("t2_hold", cpu_hold, 0);
        read_word("t2_ram0", 16'h0000, 16'hCDAB);
        read_word("t2_ram1", 16'h0001, 16'h00EF);

        // Gaps plus CPU write attempts during load.
        do_reset();
        addr = 16'h0000; writedata = 16'hDEAD; memwrite = 1'b1;
        send_byte(8'h11, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("t3_idle_ready", ld_ready, 1);
        check("t3_idle_loaded", loaded_words, 0);
        check("t3_idle_ram0", readdata, 16'hCDAB);
        send_byte(8'h22, 1'b1);
        memwrite = 1'b0;
        check("t3_loaded", loaded_words, 1);
        check("t3_hold", cpu_hold, 0);
        read_word("t3_ram0", 16'h0000, 16'h2211);
        write_word(16'hFFFF, 16'h1357);

        // Reset mid-load, then a short reload.
        do_reset();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        check("t4_mid_loaded", loaded_words, 1);
        do_reset();
        check("t4_hold", cpu_hold, 1);
        check("t4_loaded", loaded_words, 0);
        check("t4_io_out", io_out, 16'h0000);
        check("t4_ready", ld_ready, 1);
        send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b1);
        check("t4_reload_loaded", loaded_words, 1);
        read_word("t4_ram0", 16'h0000, 16'h5544);
        read_word("t4_ram1", 16'h0001, 16'h00EF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the 16-bit multicycle CPU bus (`addr`, `writedata`, `memwrite`, `readdata`).
- Provides a unified instruction/data word RAM with asynchronous read and synchronous write.
- Provides one memory-mapped output register at address 16'hFFFF.
- Provides a byte-stream boot loader. The loader fills RAM after reset and holds the CPU in reset until loading completes.

Parameters:
- DEPTH_LOG2, 8: RAM holds 2**DEPTH_LOG2 16-bit words; RAM index is addr[DEPTH_LOG2-1:0].
- IO_ADDR, 16'hFFFF: full 16-bit address of the output register.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- addr  in  16  word address from the CPU.
- writedata  in  16  write data from the CPU.
- memwrite  in  1  CPU write strobe, sampled at the rising edge.
- readdata  out  16  combinational read data to the CPU.
- ld_valid  in  1  loader byte valid.
- ld_data  in  8  loader byte.
- ld_last  in  1  marks the final byte of the image; qualified by ld_valid.
- ld_ready  out  1  responder can accept a loader byte this cycle.
- cpu_hold  out  1  active-high; drives the CPU reset while loading.
- io_out  out  16  memory-mapped output register.
- loaded_words  out  DEPTH_LOG2+1  count of words written by the loader.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=LOAD_LO, cpu_hold=1, io_out=0, loaded_words=0, load pointer=0, byte latch=0.
  - RAM contents are not cleared.
- ld_ready=1 in LOAD_LO and LOAD_HI; 0 in RUN.
- A byte transfers on a rising edge with ld_valid && ld_ready.
- Byte order is little-endian: first byte = word[7:0], second byte = word[15:8].
- LOAD_LO, on transfer:
  - Latch ld_data as the low byte.
  - If ld_last=0: go to LOAD_HI.
  - If ld_last=1: write {8'h00, ld_data} to RAM[ptr], increment loaded_words, go to RUN.
- LOAD_HI, on transfer:
  - Write {ld_data, latch} to RAM[ptr] in that same edge; ptr++, loaded_words++.
  - If ld_last=1 or ptr was 2**DEPTH_LOG2-1: go to RUN. The pointer never wraps; a full RAM ends loading even without ld_last.
  - Otherwise: go to LOAD_LO.
- No transfer in either LOAD state: hold state.
- RUN:
  - cpu_hold=0, registered. It falls on the edge that enters RUN and is valid in the first RUN cycle.
  - RUN persists until reset; the loader ignores ld_valid.
- Reset mid-load: returns to LOAD_LO with ptr=0. Partial RAM contents remain; a new image overwrites them from word 0.
- CPU reads:
  - readdata = io_out when addr==IO_ADDR; otherwise RAM[addr[DEPTH_LOG2-1:0]].
  - Zero-cycle latency (purely combinational from addr).
  - Upper address bits alias onto the RAM, except IO_ADDR.
  - Reads are valid in every state.
- CPU writes:
  - Only in RUN, on a rising edge with memwrite=1.
  - If addr==IO_ADDR: io_out<=writedata and RAM is untouched, even though IO_ADDR aliases RAM[2**DEPTH_LOG2-1].
  - Otherwise: RAM[addr index]<=writedata.
  - Write-then-read of the same address returns the new value from the next cycle.
- memwrite in any LOAD state is ignored. The CPU is held, so the loader has sole write access and there is no port contention.
- Simultaneous events:
  - A loader transfer with ld_last on the same edge as memwrite in LOAD state: only the loader write occurs.
  - CPU writes are honoured from the first RUN cycle onward.
- loaded_words saturates at 2**DEPTH_LOG2. It holds its value in RUN and is reset only by reset.

Test Plan:
- Reset low 2 cycles, then high; stream bytes 34,12,78,56(last) -> RAM[0]=16'h1234, RAM[1]=16'h5678, loaded_words=2, state RUN, cpu_hold 1 through the last transfer edge and 0 the following cycle, ld_ready=0 after.
- Odd image: bytes AB,CD,EF(last) -> RAM[0]=16'hCDAB, RAM[1]=16'h00EF, loaded_words=2, RUN.
- Backpressure/gaps: ld_valid toggled with idle cycles between bytes, memwrite=1 at addr 0 during load -> only loader data lands in RAM[0]; no state change on idle cycles.
- Overflow with DEPTH_LOG2=2: 10 bytes, no ld_last -> 4 words written, RUN entered after byte 8, bytes 9-10 not accepted (ld_ready=0), loaded_words=4.
- RUN-phase CPU access:
  - Write 16'hBEEF to addr 5 -> readdata at addr 5 = BEEF the next cycle.
  - Write 16'h00A5 to addr FFFF -> io_out=00A5, readdata at FFFF = 00A5, RAM[255] unchanged.
  - Addr 16'h0105 reads RAM[5].
- Reset mid-load after 3 bytes -> back to LOAD_LO, cpu_hold=1, loaded_words=0, io_out=0; reload 2 bytes (last) overwrites RAM[0] and the previous RAM[1] persists.
